// File: rtl/bus_source_encoder.sv
// bus_source_encoder: registered 32-to-5 bus source encoder with contention
// and reserved-source error reporting. Lowest legal strobe index wins.
module bus_source_encoder #(
  parameter int unsigned     NUM_SRC  = 24,
  parameter int unsigned     CNT_W    = 8,
  parameter logic [4:0]      IDLE_SEL = 5'b11111
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      src_out,
  input  logic             bus_hold,
  input  logic             err_ack,
  output logic [4:0]       mux_select_signal,
  output logic             bus_valid,
  output logic             conflict,
  output logic             illegal,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_count
);

  logic [NUM_SRC-1:0] legalBits;
  logic [31-NUM_SRC:0] rsvdBits;
  logic [4:0]         winIdx;
  logic               anyLegal;
  logic               multiLegal;
  logic               winFound;
  logic [CNT_W-1:0]   countInc;

  assign legalBits = src_out[NUM_SRC-1:0];
  assign rsvdBits  = src_out[31:NUM_SRC];

  // Priority-encode the legal strobes (lowest index wins) and flag contention
  always_comb begin
    winIdx     = IDLE_SEL;
    winFound   = 1'b0;
    anyLegal   = |legalBits;
    // Clearing the lowest set bit leaves something only if two or more were set
    multiLegal = |(legalBits & (legalBits - NUM_SRC'(1)));
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (legalBits[i] && !winFound) begin
        winIdx   = 5'(i);
        winFound = 1'b1;
      end
    end
  end

  // Saturating increment of the conflict counter
  always_comb begin
    countInc = (conflict_count == '1) ? conflict_count : conflict_count + CNT_W'(1);
  end

  // Output and error-log registers; hold freezes everything except the pulses
  always_ff @(posedge clock) begin
    if (!clear) begin
      mux_select_signal <= IDLE_SEL;
      bus_valid         <= 1'b0;
      conflict          <= 1'b0;
      illegal           <= 1'b0;
      conflict_sticky   <= 1'b0;
      conflict_count    <= '0;
    end else if (bus_hold) begin
      conflict <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      mux_select_signal <= anyLegal ? winIdx : IDLE_SEL;
      bus_valid         <= anyLegal;
      conflict          <= multiLegal;
      illegal           <= |rsvdBits;
      // A conflict on the acknowledge edge wins: it restarts the log at one
      if (multiLegal) begin
        conflict_sticky <= 1'b1;
        conflict_count  <= err_ack ? CNT_W'(1) : countInc;
      end else if (err_ack) begin
        conflict_sticky <= 1'b0;
        conflict_count  <= '0;
      end
    end
  end

endmodule
